// File: rtl/shift_sched_if.sv
// -----------------------------------------------------------------------------
// shift_sched_if
// Bundles the request, response and shifter-side signals of shift_sched.
//
// Signals:
//   req0_* / req1_*  : job submission from the two requesters (valid/ready,
//                      shift mode, carry-in, step count, initial data word)
//   rsp_*            : result return (valid/ready, owner id, data, carry-out)
//   sh_*             : connection to the shared clocked shifter
//   busy             : scheduler is not idle
//
// Modports:
//   slave  : the scheduler's view (takes requests, drives responses/shifter)
//   master : the environment's view (requesters, consumer and shifter)
// -----------------------------------------------------------------------------
interface shift_sched_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_mode;
    logic             req0_cin;
    logic [CNT_W-1:0] req0_count;
    logic [WIDTH-1:0] req0_data;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_mode;
    logic             req1_cin;
    logic [CNT_W-1:0] req1_count;
    logic [WIDTH-1:0] req1_data;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;

    logic [2:0]       sh_shift;
    logic             sh_cin;
    logic [WIDTH-1:0] sh_indata;
    logic [WIDTH-1:0] sh_outdata;
    logic             sh_cout;

    logic             busy;

    modport slave (
        input  req0_valid, req0_mode, req0_cin, req0_count, req0_data,
        output req0_ready,
        input  req1_valid, req1_mode, req1_cin, req1_count, req1_data,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_cout,
        input  rsp_ready,
        output sh_shift, sh_cin, sh_indata,
        input  sh_outdata, sh_cout,
        output busy
    );

    modport master (
        output req0_valid, req0_mode, req0_cin, req0_count, req0_data,
        input  req0_ready,
        output req1_valid, req1_mode, req1_cin, req1_count, req1_data,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_cout,
        output rsp_ready,
        input  sh_shift, sh_cin, sh_indata,
        output sh_outdata, sh_cout,
        input  busy
    );
endinterface

// File: rtl/shift_sched.sv
// -----------------------------------------------------------------------------
// shift_sched
// Shares one clocked shifter between two requesters. A granted job is copied
// into work registers, then the shifter is iterated once per step (two cycles
// per step: ISSUE drives the shifter inputs, WAIT captures its registered
// outputs) with each result fed back as the next input. The final word and
// carry are returned on a valid/ready response port tagged with the owner.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shift_sched_if.slave -- requests in, response out, shifter link
// -----------------------------------------------------------------------------
module shift_sched #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    shift_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    // Work registers for the job in flight.
    logic [2:0]       r_mode;
    logic             r_cin;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_data;
    logic             r_cout;
    logic             r_id;
    // Index of the most recent grant; resets to 1 so requester 0 wins the
    // first tie.
    logic             r_last;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [2:0]       w_sel_mode;
    logic             w_sel_cin;
    logic [CNT_W-1:0] w_sel_count;
    logic [WIDTH-1:0] w_sel_data;

    logic             w_req0_ready;
    logic             w_req1_ready;
    logic             w_rsp_valid;
    logic             w_busy;
    logic [2:0]       w_sh_shift;
    logic             w_sh_cin;
    logic [WIDTH-1:0] w_sh_indata;

    // Round-robin: on a tie the requester that did not win last time is
    // chosen; a lone request is always granted.
    always_comb begin
        w_gnt1   = bus.req1_valid & (~bus.req0_valid | ~r_last);
        w_gnt0   = bus.req0_valid & ~w_gnt1;
        w_accept = (r_state == S_IDLE) & (bus.req0_valid | bus.req1_valid);

        if (w_gnt1) begin
            w_sel_mode  = bus.req1_mode;
            w_sel_cin   = bus.req1_cin;
            w_sel_count = bus.req1_count;
            w_sel_data  = bus.req1_data;
        end else begin
            w_sel_mode  = bus.req0_mode;
            w_sel_cin   = bus.req0_cin;
            w_sel_count = bus.req0_count;
            w_sel_data  = bus.req0_data;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_rsp_valid  = 1'b0;
        w_busy       = 1'b1;
        w_sh_shift   = 3'd0;
        w_sh_cin     = 1'b0;
        w_sh_indata  = '0;

        case (r_state)
            S_IDLE: begin
                w_busy       = 1'b0;
                w_req0_ready = (r_state == S_IDLE) & w_gnt0;
                w_req1_ready = (r_state == S_IDLE) & w_gnt1;
                if (w_accept) begin
                    // A zero-step job skips the shifter entirely.
                    w_next = (w_sel_count != '0) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                w_sh_shift  = r_mode;
                w_sh_cin    = r_cin;
                w_sh_indata = r_data;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                // Inputs are held so the shifter sees them on its capture edge.
                w_sh_shift  = r_mode;
                w_sh_cin    = r_cin;
                w_sh_indata = r_data;
                w_next      = (r_rem == CNT_W'(1)) ? S_RESP : S_ISSUE;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 3'd0;
            r_cin   <= 1'b0;
            r_rem   <= '0;
            r_data  <= '0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode <= w_sel_mode;
                        r_cin  <= w_sel_cin;
                        r_rem  <= w_sel_count;
                        r_data <= w_sel_data;
                        r_cout <= 1'b0;
                        r_id   <= w_gnt1;
                        r_last <= w_gnt1;
                    end
                end
                S_WAIT: begin
                    // Feed the shifter result back as the next step's input.
                    r_data <= bus.sh_outdata;
                    r_cout <= bus.sh_cout;
                    r_rem  <= r_rem - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_data   = r_data;
    assign bus.rsp_cout   = r_cout;
    assign bus.sh_shift   = w_sh_shift;
    assign bus.sh_cin     = w_sh_cin;
    assign bus.sh_indata  = w_sh_indata;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_shift_sched.sv
module tb_shift_sched;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_sched_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Shifter behaviour: 1 = shl (LSB<-cin, cout<-MSB), 2 = shr (MSB<-cin,
    // cout<-LSB), 3 = rotate left (cout<-MSB), otherwise pass-through.
    function automatic logic [16:0] sh_step(input logic [2:0] m, input logic c, input logic [15:0] d);
        case (m)
            3'd1:    return {d[15], d[14:0], c};
            3'd2:    return {d[0], c, d[15:1]};
            3'd3:    return {d[15], d[14:0], d[15]};
            default: return {1'b0, d};
        endcase
    endfunction

    // {cout, data} after n steps; zero steps gives data unchanged, cout 0.
    function automatic logic [16:0] iter(input logic [2:0] m, input logic c, input logic [15:0] d, input int n);
        logic [16:0] r;
        r = {1'b0, d};
        for (int i = 0; i < n; i++) r = sh_step(m, c, r[15:0]);
        return r;
    endfunction

    // Registered stand-in for the shared shifter.
    always @(posedge clk) begin
        {bus.sh_cout, bus.sh_outdata} <= sh_step(bus.sh_shift, bus.sh_cin, bus.sh_indata);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          m_idle = 1'b1;
    bit          m_last = 1'b1;
    bit          m_id   = 1'b0;
    int          m_e    = 0;
    int          m_cnt  = 0;
    logic [2:0]  m_mode = 3'd0;
    logic        m_cin  = 1'b0;
    logic [15:0] m_d0   = 16'h0;
    logic [16:0] m_res  = 17'h0;

    always @(negedge clk) begin
        bit g0, g1, in_cmp, in_rsp;
        logic [16:0] cur;
        if (!rst_n) begin
            m_idle = 1'b1;
            m_last = 1'b1;
        end
        g1 = m_idle && bus.req1_valid && (!bus.req0_valid || !m_last);
        g0 = m_idle && bus.req0_valid && !g1;
        in_cmp = !m_idle && (m_e >= 1) && (m_e <= 2 * m_cnt);
        in_rsp = !m_idle && (m_e >= 2 * m_cnt + 1);

        chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(in_rsp));
        chk("busy", 32'(bus.busy), 32'(!m_idle));
        if (in_rsp) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            chk("rsp_data", 32'(bus.rsp_data), 32'(m_res[15:0]));
            chk("rsp_cout", 32'(bus.rsp_cout), 32'(m_res[16]));
        end
        if (!rst_n) begin
            chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
            chk("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        end
        if (in_cmp) begin
            cur = iter(m_mode, m_cin, m_d0, (m_e - 1) / 2);
            chk("sh_shift", 32'(bus.sh_shift), 32'(m_mode));
            chk("sh_cin", 32'(bus.sh_cin), 32'(m_cin));
            chk("sh_indata", 32'(bus.sh_indata), 32'(cur[15:0]));
        end else begin
            chk("sh_shift_idle", 32'(bus.sh_shift), 32'd0);
            chk("sh_cin_idle", 32'(bus.sh_cin), 32'd0);
            chk("sh_indata_idle", 32'(bus.sh_indata), 32'd0);
        end

        if (rst_n) begin
            if (m_idle) begin
                if (g0 || g1) begin
                    m_id   = g1;
                    m_last = g1;
                    m_mode = g1 ? bus.req1_mode : bus.req0_mode;
                    m_cin  = g1 ? bus.req1_cin : bus.req0_cin;
                    m_cnt  = int'(g1 ? bus.req1_count : bus.req0_count);
                    m_d0   = g1 ? bus.req1_data : bus.req0_data;
                    m_res  = iter(m_mode, m_cin, m_d0, m_cnt);
                    m_e    = 1;
                    m_idle = 1'b0;
                end
            end else if (in_rsp && bus.rsp_ready) begin
                m_idle = 1'b1;
            end else begin
                m_e++;
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic drive(input bit who, input logic [2:0] m, input logic c, input logic [3:0] n, input logic [15:0] d);
        if (who) begin
            bus.req1_mode = m; bus.req1_cin = c; bus.req1_count = n; bus.req1_data = d; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_mode = m; bus.req0_cin = c; bus.req0_count = n; bus.req0_data = d; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_mode = 3'd0; bus.req0_cin = 1'b0; bus.req0_count = 4'd0; bus.req0_data = 16'h0;
        bus.req1_valid = 1'b0; bus.req1_mode = 3'd0; bus.req1_cin = 1'b0; bus.req1_count = 4'd0; bus.req1_data = 16'h0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_job(input string nm, input bit who, input logic [2:0] m, input logic c,
                           input logic [3:0] n, input logic [15:0] d,
                           input int exp_lat, input logic [15:0] exp_d, input logic exp_c);
        int lat;
        @(posedge clk); #1;
        drive(who, m, c, n, d);
        @(posedge clk); #1;     // accept edge has passed
        clear_reqs();
        wait_rsp(lat);
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
        chk({nm, "_cout"}, 32'(bus.rsp_cout), 32'(exp_c));
        chk({nm, "_id"}, 32'(bus.rsp_id), 32'(who));
        @(posedge clk); #1;     // handshake edge (rsp_ready is high)
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        bit seen;
        clear_reqs();
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_sh_shift", 32'(bus.sh_shift), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_job("single", 1'b0, 3'd1, 1'b1, 4'd3, 16'h1111, 7, 16'h888F, 1'b0);
        run_job("zero", 1'b1, 3'd1, 1'b1, 4'd0, 16'h1FF1, 1, 16'h1FF1, 1'b0);
        run_job("shr", 1'b1, 3'd2, 1'b1, 4'd2, 16'h0003, 5, 16'hC000, 1'b1);

        // Tie: both valid continuously after reset; grants alternate from 0.
        pulse_reset();
        drive(1'b0, 3'd1, 1'b0, 4'd1, 16'h0001);
        drive(1'b1, 3'd3, 1'b0, 4'd2, 16'hC000);
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("tie_grant_seen", 32'(seen), 32'd1);
            chk("tie_grant_id", 32'(bus.req1_ready), 32'(k % 2));
            @(posedge clk); #1;
        end
        clear_reqs();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        chk("tie_drain", 32'(bus.busy), 32'd0);

        // Backpressure: response held for 10 cycles while requests wait.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 3'd1, 1'b0, 4'd2, 16'h00F0);
        @(posedge clk); #1;
        clear_reqs();
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 32'd5);
        @(posedge clk); #1;
        drive(1'b0, 3'd1, 1'b1, 4'd1, 16'h1234);
        drive(1'b1, 3'd1, 1'b1, 4'd1, 16'h4321);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_data", 32'(bus.rsp_data), 32'h03C0);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
        end
        @(posedge clk); #1;
        clear_reqs();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Reset during WAIT drops the job.
        drive(1'b0, 3'd1, 1'b1, 4'd5, 16'h0101);
        @(posedge clk); #1;
        clear_reqs();
        @(posedge clk); #1;
        chk("mid_wait_shift", 32'(bus.sh_shift), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_shift", 32'(bus.sh_shift), 32'd0);
        chk("mid_rst_indata", 32'(bus.sh_indata), 32'd0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.rsp_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
        end

        run_job("max", 1'b0, 3'd1, 1'b0, 4'd15, 16'h8000, 31, 16'h0000, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
